// File: rtl/imem_boot_loader.sv
// Framed byte-stream loader for the core's instruction memory: assembles little-endian
// words, writes them at BASE_ADDR upward, and releases the core only after a good checksum.
module imem_boot_loader #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        core_rst,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] words_loaded,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_LO = 3'd1,
      S_LEN_HI = 3'd2,
      S_DATA   = 3'd3,
      S_CSUM   = 3'd4,
      S_DONE   = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   state_t                state_q, state_d;
   logic [7:0]            csum_q, csum_d;
   logic [1:0]            byte_cnt_q, byte_cnt_d;
   logic [23:0]           asm_q, asm_d;
   logic [15:0]           len_q, len_d;
   logic [ADDR_WIDTH:0]   word_idx_q, word_idx_d;
   logic [15:0]           words_loaded_q, words_loaded_d;
   logic                  imem_we_q, imem_we_d;
   logic [31:0]           imem_addr_q, imem_addr_d;
   logic [31:0]           imem_wdata_q, imem_wdata_d;
   logic                  accept;
   logic [15:0]           n_w;

   // Handshake: a byte moves on every cycle where rx_valid && rx_ready; rx_ready depends
   // only on state, never on rx_valid, so a producer may hold rx_valid high indefinitely.
   assign busy     = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                     (state_q == S_DATA)   || (state_q == S_CSUM);
   assign rx_ready = busy;
   assign accept   = rx_valid && rx_ready;
   assign n_w      = {rx_data, len_q[7:0]};

   always_comb begin
      state_d        = state_q;
      csum_d         = csum_q;
      byte_cnt_d     = byte_cnt_q;
      asm_d          = asm_q;
      len_d          = len_q;
      word_idx_d     = word_idx_q;
      words_loaded_d = words_loaded_q;
      imem_we_d      = 1'b0;
      imem_addr_d    = imem_addr_q;
      imem_wdata_d   = imem_wdata_q;

      if (accept) csum_d = csum_q ^ rx_data;

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (state_q == S_IDLE || start) begin
               csum_d         = 8'h00;
               byte_cnt_d     = 2'd0;
               word_idx_d     = '0;
               words_loaded_d = 16'd0;
            end
            if (start) state_d = S_LEN_LO;
         end
         S_LEN_LO: begin
            if (accept) begin
               len_d   = {8'h00, rx_data};
               state_d = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (accept) begin
               len_d = n_w;
               if (n_w == 16'd0)                               state_d = S_CSUM;
               else if (32'(n_w) > (32'd1 << ADDR_WIDTH))      state_d = S_ERR;
               else                                            state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (accept) begin
               byte_cnt_d = byte_cnt_q + 2'd1;
               case (byte_cnt_q)
                  2'd0: asm_d[7:0]   = rx_data;
                  2'd1: asm_d[15:8]  = rx_data;
                  2'd2: asm_d[23:16] = rx_data;
                  default: begin
                     imem_wdata_d   = {rx_data, asm_q};
                     imem_addr_d    = BASE_ADDR + (32'(word_idx_q) << 2);
                     imem_we_d      = 1'b1;
                     word_idx_d     = word_idx_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
                     words_loaded_d = words_loaded_q + 16'd1;
                     if (32'(word_idx_q) + 32'd1 == 32'(len_q)) state_d = S_CSUM;
                  end
               endcase
            end
         end
         S_CSUM: begin
            if (accept) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         csum_q         <= 8'h00;
         byte_cnt_q     <= 2'd0;
         asm_q          <= 24'h0;
         len_q          <= 16'h0;
         word_idx_q     <= '0;
         words_loaded_q <= 16'd0;
         imem_we_q      <= 1'b0;
         imem_addr_q    <= 32'h0;
         imem_wdata_q   <= 32'h0;
      end else begin
         state_q        <= state_d;
         csum_q         <= csum_d;
         byte_cnt_q     <= byte_cnt_d;
         asm_q          <= asm_d;
         len_q          <= len_d;
         word_idx_q     <= word_idx_d;
         words_loaded_q <= words_loaded_d;
         imem_we_q      <= imem_we_d;
         imem_addr_q    <= imem_addr_d;
         imem_wdata_q   <= imem_wdata_d;
      end
   end

   assign imem_we      = imem_we_q;
   assign imem_addr    = imem_addr_q;
   assign imem_wdata   = imem_wdata_q;
   assign words_loaded = words_loaded_q;
   assign done         = (state_q == S_DONE);
   assign error        = (state_q == S_ERR);
   assign core_rst     = done;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: frame loads, checksum failure, empty and oversize
// frames, gappy stream with a stray start, and reset in the middle of a word.
module tb_imem_boot_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        core_rst;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] words_loaded;
   logic [2:0]  dbg_state;

   int total = 0;
   int bad   = 0;

   // {words_loaded, addr, data} expected at each write strobe
   logic [79:0] exp_q[$];
   logic [79:0] exp_e;
   logic [7:0]  frm[$];
   logic        prev_we = 1'b0;

   localparam logic [2:0] ST_DATA = 3'd3;
   localparam logic [2:0] ST_ERR  = 3'd6;

   imem_boot_loader #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .core_rst(core_rst), .busy(busy), .done(done), .error(error),
      .words_loaded(words_loaded), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         chk("we_single_cycle", 32'(prev_we), 32'd0);
         total++;
         assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_write got addr=%h data=%h exp none", imem_addr, imem_wdata);
         end
         if (exp_q.size() != 0) begin
            exp_e = exp_q.pop_front();
            chk("wr_addr", imem_addr, exp_e[63:32]);
            chk("wr_data", imem_wdata, exp_e[31:0]);
            chk("wr_words_loaded", 32'(words_loaded), 32'(exp_e[79:64]));
         end
      end
      prev_we = imem_we;
   end

   task automatic chk_reset_outs(input string pfx);
      chk({pfx, "_rx_ready"}, 32'(rx_ready), 32'd0);
      chk({pfx, "_imem_we"}, 32'(imem_we), 32'd0);
      chk({pfx, "_imem_addr"}, imem_addr, 32'd0);
      chk({pfx, "_imem_wdata"}, imem_wdata, 32'd0);
      chk({pfx, "_core_rst"}, 32'(core_rst), 32'd0);
      chk({pfx, "_busy"}, 32'(busy), 32'd0);
      chk({pfx, "_done"}, 32'(done), 32'd0);
      chk({pfx, "_error"}, 32'(error), 32'd0);
      chk({pfx, "_words_loaded"}, 32'(words_loaded), 32'd0);
      chk({pfx, "_state"}, 32'(dbg_state), 32'd0);
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int max_gap);
      int n;
      n = 0;
      if (max_gap > 0) begin
         rx_valid = 1'b0;
         rx_data  = 8'($urandom_range(0, 255));
         repeat ($urandom_range(0, max_gap)) @(posedge clk);
         #1;
      end
      rx_data  = b;
      rx_valid = 1'b1;
      while (rx_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rx_ready_wait", 32'(rx_ready), 32'd1);
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input int max_gap);
      for (int i = 0; i < frm.size(); i++) send_byte(frm[i], max_gap);
   endtask

   // Two words 0x00500513, 0x00A00593; XOR of the ten bytes before CSUM is 0x72.
   task automatic frame_a(input logic [7:0] cs);
      frm = {8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00, cs};
   endtask

   task automatic push_a();
      exp_q.push_back({16'd1, 32'h0000_0000, 32'h0050_0513});
      exp_q.push_back({16'd2, 32'h0000_0004, 32'h00A0_0593});
   endtask

   initial begin
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outs("rst_hold");
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      chk_reset_outs("rst_release");

      // good two-word load
      pulse_start();
      @(negedge clk);
      chk("a_busy", 32'(busy), 32'd1);
      chk("a_rx_ready", 32'(rx_ready), 32'd1);
      chk("a_core_held", 32'(core_rst), 32'd0);
      push_a();
      frame_a(8'h72);
      send_frame(0);
      @(negedge clk);
      chk("a_done", 32'(done), 32'd1);
      chk("a_core_rst", 32'(core_rst), 32'd1);
      chk("a_error", 32'(error), 32'd0);
      chk("a_words_loaded", 32'(words_loaded), 32'd2);
      chk("a_busy_end", 32'(busy), 32'd0);
      chk("a_rx_ready_end", 32'(rx_ready), 32'd0);
      chk("a_pending", 32'(exp_q.size()), 32'd0);

      // same frame, bad checksum
      pulse_start();
      @(negedge clk);
      chk("b_done_clear", 32'(done), 32'd0);
      chk("b_core_held", 32'(core_rst), 32'd0);
      push_a();
      frame_a(8'h39);
      send_frame(0);
      @(negedge clk);
      chk("b_error", 32'(error), 32'd1);
      chk("b_done", 32'(done), 32'd0);
      chk("b_core_rst", 32'(core_rst), 32'd0);
      chk("b_words_loaded", 32'(words_loaded), 32'd2);
      chk("b_pending", 32'(exp_q.size()), 32'd0);

      // empty frame
      pulse_start();
      @(negedge clk);
      chk("z_error_clear", 32'(error), 32'd0);
      frm = {8'h00, 8'h00, 8'h00};
      send_frame(0);
      @(negedge clk);
      chk("z_done", 32'(done), 32'd1);
      chk("z_core_rst", 32'(core_rst), 32'd1);
      chk("z_words_loaded", 32'(words_loaded), 32'd0);

      // N = 0x0401 exceeds 1024 words
      pulse_start();
      frm = {8'h01, 8'h04};
      send_frame(0);
      @(negedge clk);
      chk("big_error", 32'(error), 32'd1);
      chk("big_rx_ready", 32'(rx_ready), 32'd0);
      chk("big_busy", 32'(busy), 32'd0);
      chk("big_words_loaded", 32'(words_loaded), 32'd0);
      rx_data  = 8'h55;
      rx_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("big_ignore_ready", 32'(rx_ready), 32'd0);
      chk("big_ignore_state", 32'(dbg_state), 32'(ST_ERR));
      rx_valid = 1'b0;

      // one word 0x12345678: 01^00^78^56^34^12 = 0x09
      pulse_start();
      exp_q.push_back({16'd1, 32'h0000_0000, 32'h1234_5678});
      frm = {8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
      send_frame(0);
      @(negedge clk);
      chk("c_done", 32'(done), 32'd1);
      chk("c_words_loaded", 32'(words_loaded), 32'd1);
      chk("c_pending", 32'(exp_q.size()), 32'd0);

      // gappy stream with a stray start after the first word
      pulse_start();
      push_a();
      frame_a(8'h72);
      for (int i = 0; i < frm.size(); i++) begin
         send_byte(frm[i], 3);
         if (i == 5) begin
            pulse_start();
            @(negedge clk);
            chk("g_busy_after_start", 32'(busy), 32'd1);
            chk("g_state_after_start", 32'(dbg_state), 32'(ST_DATA));
            chk("g_words_after_start", 32'(words_loaded), 32'd1);
         end
      end
      @(negedge clk);
      chk("g_done", 32'(done), 32'd1);
      chk("g_words_loaded", 32'(words_loaded), 32'd2);
      chk("g_pending", 32'(exp_q.size()), 32'd0);

      // reset after 1.5 words, then a fresh load
      pulse_start();
      exp_q.push_back({16'd1, 32'h0000_0000, 32'h0050_0513});
      frame_a(8'h72);
      for (int i = 0; i < 8; i++) send_byte(frm[i], 0);
      @(negedge clk);
      chk("r_words_before", 32'(words_loaded), 32'd1);
      rst = 1'b0;
      #1;
      chk_reset_outs("r_in_reset");
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      chk_reset_outs("r_released");
      chk("r_pending", 32'(exp_q.size()), 32'd0);
      pulse_start();
      push_a();
      send_frame(0);
      @(negedge clk);
      chk("r_done", 32'(done), 32'd1);
      chk("r_words_loaded", 32'(words_loaded), 32'd2);
      chk("r_pending_end", 32'(exp_q.size()), 32'd0);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
